// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_pkg
//  Purpose : Shared encodings for the memory access unit: request size codes,
//            controller state encoding and the byte-lane mask helper.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Request size encodings carried on req_size.
    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Byte-enable mask for an access of the given size starting at the given
    // lane. Alignment is checked before this mask is used, so a half access
    // never starts at lane 3 and a word access always starts at lane 0.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] lane);
        logic [3:0] mask;
        case (size)
            SZ_B:    mask = 4'b0001 << lane;
            SZ_H:    mask = 4'b0011 << lane;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
//  Module  : mem_align
//  Purpose : Combinational lane alignment for the memory access unit.
//            - store merge  : inserts right-aligned store data into the old
//                             word at the addressed lane(s)
//            - load extract : pulls the addressed byte/half out of a word and
//                             sign- or zero-extends it
//  Ports   : old_word_i  old ram word for read-modify-write
//            wdata_i     store data, right-aligned
//            word_i      ram word for load extraction
//            size_i      access size (SZ_B / SZ_H / SZ_W)
//            lane_i      byte lane within the word (addr[1:0])
//            sext_i      1 = sign-extend load result
//            merged_o    merged word to write back
//            rdata_o     extracted and extended load result
//  Revision: 1.0 - initial release
// ============================================================================
module mem_align (
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        sext_i,
    output logic [31:0] merged_o,
    output logic [31:0] rdata_o
);
    import mem_pkg::*;

    logic [3:0]  w_mask;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_mask    = lane_mask(size_i, lane_i);
    assign w_shifted = wdata_i << {lane_i, 3'b000};

    // Per-byte select: addressed lanes take the new data, others keep old.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged_o[8*i +: 8] = w_mask[i] ? w_shifted[8*i +: 8]
                                              : old_word_i[8*i +: 8];
    end

    assign w_byte = word_i[{lane_i, 3'b000} +: 8];
    assign w_half = word_i[{lane_i[1], 4'b0000} +: 16];

    always_comb begin
        rdata_o = word_i;
        case (size_i)
            SZ_B:    rdata_o = {{24{sext_i & w_byte[7]}}, w_byte};
            SZ_H:    rdata_o = {{16{sext_i & w_half[15]}}, w_half};
            default: rdata_o = word_i;
        endcase
    end

endmodule : mem_align
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module  : mem_access_unit
//  Purpose : Initiator-side controller for a word-addressed ram. Converts
//            byte-addressed load/store requests into word accesses, performs
//            read-modify-write for sub-word stores and returns load data or
//            store completion on a response channel (one outstanding).
//  Ports   : sys_clk/sys_rst        clock, asynchronous active-high reset
//            req_*                  request channel (valid/ready)
//            rsp_*                  response channel (valid/ready)
//            ram_raddr/ram_rdata    ram read port (combinational read)
//            ram_waddr/ram_wdata/ram_wen  ram write port (posedge write)
//  Revision: 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_SIZE = 12,
    parameter int DATA_SIZE = 32
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [1:0]           req_size,
    input  logic                 req_sext,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [ADDR_SIZE-1:0] ram_raddr,
    input  logic [DATA_SIZE-1:0] ram_rdata,
    output logic [ADDR_SIZE-1:0] ram_waddr,
    output logic [DATA_SIZE-1:0] ram_wdata,
    output logic                 ram_wen
);
    import mem_pkg::*;

    state_e               state_q, state_d;
    logic                 we_q;
    logic [1:0]           size_q;
    logic                 sext_q;
    logic [1:0]           lane_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rsp_rdata_q;
    logic                 rsp_err_q;
    logic [ADDR_SIZE-1:0] raddr_q;
    logic [ADDR_SIZE-1:0] waddr_q;
    logic [DATA_SIZE-1:0] ram_wdata_q;

    logic [31:0]          w_addr_hi;
    logic                 w_err;
    logic                 w_accept;
    logic [ADDR_SIZE-1:0] w_idx;
    logic [31:0]          w_merged;
    logic [31:0]          w_extract;

    // Any byte address beyond the ram leaves bits above the word index set.
    assign w_addr_hi = req_addr >> (ADDR_SIZE + 2);
    assign w_idx     = req_addr[ADDR_SIZE+1:2];
    assign w_err     = (req_size == SZ_ILL)
                     | ((req_size == SZ_H) & req_addr[0])
                     | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00))
                     | (w_addr_hi != 32'd0);

    assign w_accept  = req_valid & (state_q == ST_IDLE);

    mem_align u_align (
        .old_word_i (ram_rdata),
        .wdata_i    (wdata_q),
        .word_i     (ram_rdata),
        .size_i     (size_q),
        .lane_i     (lane_q),
        .sext_i     (sext_q),
        .merged_o   (w_merged),
        .rdata_o    (w_extract)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_err)
                        state_d = ST_RESP;
                    else if (req_we && (req_size == SZ_W))
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;   // load, or read half of a RMW
                end
            end
            ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            sext_q      <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        we_q        <= req_we;
                        size_q      <= req_size;
                        sext_q      <= req_sext;
                        lane_q      <= req_addr[1:0];
                        wdata_q     <= req_wdata;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= w_err;
                        if (!w_err) begin
                            raddr_q <= w_idx;
                            waddr_q <= w_idx;
                            // Full-word stores skip the read and write directly.
                            if (req_we && (req_size == SZ_W))
                                ram_wdata_q <= req_wdata;
                        end
                    end
                end
                ST_RD: begin
                    if (we_q)
                        ram_wdata_q <= w_merged;
                    else
                        rsp_rdata_q <= w_extract;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state register so an asynchronous
    // reset removes them in the same instant the state returns to IDLE.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign ram_wen   = (state_q == ST_WR);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign ram_raddr = raddr_q;
    assign ram_waddr = waddr_q;
    assign ram_wdata = ram_wdata_q;

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_access_unit
//  Purpose : Directed self-checking bench for mem_access_unit with an
//            attached behavioural ram (combinational read, posedge write).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int AS = 12;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = 32'd0;
    logic [1:0]    req_size = 2'b00;
    logic          req_sext = 1'b0;
    logic [31:0]   req_wdata = 32'd0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AS-1:0] ram_raddr;
    logic [31:0]   ram_rdata;
    logic [AS-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic          ram_wen;

    int n_cmp = 0;
    int n_bad = 0;
    int wen_cnt = 0;

    logic [31:0] mem [0:(1<<AS)-1];

    always #5 sys_clk = ~sys_clk;

    assign ram_rdata = mem[ram_raddr];

    always @(posedge sys_clk) begin
        if (ram_wen) begin
            mem[ram_waddr] <= ram_wdata;
            wen_cnt        <= wen_cnt + 1;
        end
    end

    mem_access_unit #(.ADDR_SIZE(AS), .DATA_SIZE(32)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_sext  (req_sext),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_wen   (ram_wen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // One complete transaction. lat counts clock cycles from the acceptance
    // edge to the first cycle rsp_valid is seen (99 when it never appears).
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic sext, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err, output int lat);
        int t;
        @(negedge sys_clk);
        req_we = we; req_addr = addr; req_size = size; req_sext = sext; req_wdata = wdata;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge sys_clk);
            t++;
        end
        chk("accept", {31'd0, req_ready}, 32'd1);
        @(posedge sys_clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge sys_clk);
            lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) lat = 99;
        rd  = rsp_rdata;
        err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge sys_clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          wc;

        for (int i = 0; i < (1<<AS); i++) mem[i] <= 32'd0;
        #1;
        mem[5] <= 32'h5566_7788;
        mem[8] <= 32'h1122_3344;

        // ---- reset state ----
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_ram_wen",   {31'd0, ram_wen},   32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("rst_raddr",     {20'd0, ram_raddr}, 32'd0);
        chk("rst_waddr",     {20'd0, ram_waddr}, 32'd0);
        chk("rst_wdata",     ram_wdata, 32'd0);
        sys_rst = 1'b0;

        // ---- word store then word load ----
        wc = wen_cnt;
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, rd, err, lat);
        chk("sw_lat",   lat, 32'd2);
        chk("sw_err",   {31'd0, err}, 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_mem4",  mem[4], 32'hDEAD_BEEF);
        chk("sw_wen",   wen_cnt - wc, 32'd1);

        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, rd, err, lat);
        chk("lw_lat",   lat, 32'd2);
        chk("lw_rdata", rd, 32'hDEAD_BEEF);
        chk("lw_err",   {31'd0, err}, 32'd0);

        // ---- byte store (RMW) and byte loads ----
        wc = wen_cnt;
        do_req(1'b1, 32'h13, 2'b00, 1'b0, 32'h0000_00AA, rd, err, lat);
        chk("sb_lat",  lat, 32'd3);
        chk("sb_mem4", mem[4], 32'hAAAD_BEEF);
        chk("sb_wen",  wen_cnt - wc, 32'd1);

        do_req(1'b0, 32'h13, 2'b00, 1'b1, 32'd0, rd, err, lat);
        chk("lb_sext", rd, 32'hFFFF_FFAA);
        chk("lb_lat",  lat, 32'd2);
        do_req(1'b0, 32'h13, 2'b00, 1'b0, 32'd0, rd, err, lat);
        chk("lb_zext", rd, 32'h0000_00AA);
        do_req(1'b0, 32'h10, 2'b00, 1'b1, 32'd0, rd, err, lat);
        chk("lb0_sext", rd, 32'hFFFF_FFEF);
        do_req(1'b0, 32'h11, 2'b00, 1'b0, 32'd0, rd, err, lat);
        chk("lb1_zext", rd, 32'h0000_00BE);

        // ---- error cases ----
        wc = wen_cnt;
        do_req(1'b0, 32'h11, 2'b01, 1'b0, 32'd0, rd, err, lat);
        chk("e_half_err", {31'd0, err}, 32'd1);
        chk("e_half_rd",  rd, 32'd0);
        chk("e_half_lat", lat, 32'd1);
        do_req(1'b1, 32'h4000, 2'b10, 1'b0, 32'hCAFE_F00D, rd, err, lat);
        chk("e_range_err", {31'd0, err}, 32'd1);
        chk("e_range_rd",  rd, 32'd0);
        chk("e_range_lat", lat, 32'd1);
        chk("e_range_mem0", mem[0], 32'd0);
        do_req(1'b0, 32'h10, 2'b11, 1'b0, 32'd0, rd, err, lat);
        chk("e_size_err", {31'd0, err}, 32'd1);
        chk("e_size_rd",  rd, 32'd0);
        chk("e_size_lat", lat, 32'd1);
        do_req(1'b1, 32'h12, 2'b10, 1'b0, 32'h1111_1111, rd, err, lat);
        chk("e_wmis_err", {31'd0, err}, 32'd1);
        chk("e_wmis_mem4", mem[4], 32'hAAAD_BEEF);
        chk("e_no_wen", wen_cnt - wc, 32'd0);

        // ---- half store at upper lane, then half loads ----
        do_req(1'b1, 32'h16, 2'b01, 1'b0, 32'h0000_1234, rd, err, lat);
        chk("sh_lat",  lat, 32'd3);
        chk("sh_mem5", mem[5], 32'h1234_7788);
        do_req(1'b0, 32'h16, 2'b01, 1'b1, 32'd0, rd, err, lat);
        chk("lh_hi_sext", rd, 32'h0000_1234);
        do_req(1'b0, 32'h14, 2'b01, 1'b1, 32'd0, rd, err, lat);
        chk("lh_lo_sext", rd, 32'h0000_7788);
        do_req(1'b0, 32'h12, 2'b01, 1'b1, 32'd0, rd, err, lat);
        chk("lh_neg_sext", rd, 32'hFFFF_AAAD);
        do_req(1'b0, 32'h12, 2'b01, 1'b0, 32'd0, rd, err, lat);
        chk("lh_neg_zext", rd, 32'h0000_AAAD);

        // ---- response back-pressure ----
        @(negedge sys_clk);
        req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_sext = 1'b0;
        req_valid = 1'b1;
        @(posedge sys_clk);
        #1 req_valid = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("hold_valid0", {31'd0, rsp_valid}, 32'd1);
        chk("hold_rdata0", rsp_rdata, 32'hAAAD_BEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, 32'hAAAD_BEEF);
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge sys_clk);
        #1 rsp_ready = 1'b0;
        @(negedge sys_clk);
        chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
        chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
        do_req(1'b0, 32'h14, 2'b10, 1'b0, 32'd0, rd, err, lat);
        chk("post_hs_load", rd, 32'h1234_7788);

        // ---- reset during read phase of a byte store ----
        wc = wen_cnt;
        @(negedge sys_clk);
        req_we = 1'b1; req_addr = 32'h21; req_size = 2'b00; req_wdata = 32'h0000_00FF;
        req_valid = 1'b1;
        @(posedge sys_clk);
        #1 req_valid = 1'b0;
        chk("rd_phase_ready", {31'd0, req_ready}, 32'd0);
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_wen",   {31'd0, ram_wen},   32'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge sys_clk);
            chk("drop_no_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("drop_ready",  {31'd0, req_ready}, 32'd1);
        end
        chk("drop_no_wen", wen_cnt - wc, 32'd0);
        chk("drop_mem8",   mem[8], 32'h1122_3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mem_access_unit
`default_nettype wire
